// File: rtl/modbus_crc16_rx_check_if.sv
// rtl/modbus_crc16_rx_check_if.sv - byte stream and verdict bundle for the CRC-16/MODBUS receive checker
interface modbus_crc16_rx_check_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        eof;
    logic        frame_done;
    logic        crc_ok;
    logic        overrun;
    logic [8:0]  frame_len;
    logic [15:0] crc_res;

    modport master (
        output rx_byte, rx_valid, eof,
        input  rx_ready, frame_done, crc_ok, overrun, frame_len, crc_res
    );

    modport slave (
        input  rx_byte, rx_valid, eof,
        output rx_ready, frame_done, crc_ok, overrun, frame_len, crc_res
    );
endinterface

// File: rtl/modbus_crc16_rx_check.sv
// rtl/modbus_crc16_rx_check.sv - CRC-16/MODBUS receive checker (bit-serial; CRC_RX_BYTEWISE_EN selects one byte per cycle)
module modbus_crc16_rx_check #(
    parameter int MAX_LEN = 256,
    parameter int MIN_LEN = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    modbus_crc16_rx_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [8:0]  MAX9     = 9'(MAX_LEN);
    localparam logic [8:0]  MIN9     = 9'(MIN_LEN);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [8:0]  len_q, len_d;
    logic        ovr_q, ovr_d;
    logic        latch;
    logic        ready;
`ifndef CRC_RX_BYTEWISE_EN
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
`endif

    logic        ok_q, ovr_out_q;
    logic [8:0]  len_out_q;
    logic [15:0] res_out_q;
    logic        ok_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c);
        return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    endfunction

`ifdef CRC_RX_BYTEWISE_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = crc_step(r);
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        ovr_d   = ovr_q;
        latch   = 1'b0;
        ready   = 1'b0;
`ifndef CRC_RX_BYTEWISE_EN
        cnt_d   = cnt_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.rx_valid) begin
                    // Bytes past MAX_LEN are swallowed so the frame still ends on eof.
                    if (len_q < MAX9) len_d = len_q + 9'd1;
                    else              ovr_d = 1'b1;
`ifdef CRC_RX_BYTEWISE_EN
                    crc_d = crc_byte(crc_q, bus.rx_byte);
                    if (bus.eof) begin
                        latch   = 1'b1;
                        state_d = DONE;
                    end
`else
                    crc_d   = crc_q ^ {8'h00, bus.rx_byte};
                    cnt_d   = 3'd0;
                    pend_d  = bus.eof;
                    state_d = SHIFT;
`endif
                end else if (bus.eof && len_q != 9'd0) begin
                    latch   = 1'b1;
                    state_d = DONE;
                end
            end
`ifndef CRC_RX_BYTEWISE_EN
            SHIFT: begin
                crc_d = crc_step(crc_q);
                cnt_d = cnt_q + 3'd1;
                if (bus.eof) pend_d = 1'b1;
                if (cnt_q == 3'd7) begin
                    if (pend_q || bus.eof) begin
                        latch   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                crc_d   = CRC_INIT;
                len_d   = 9'd0;
                ovr_d   = 1'b0;
`ifndef CRC_RX_BYTEWISE_EN
                pend_d  = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Verdict is taken from the next-state values so the last byte/shift is included.
    assign ok_d = (crc_d == 16'h0000) && (len_d >= MIN9) && (len_d <= MAX9) && !ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            len_q     <= 9'd0;
            ovr_q     <= 1'b0;
`ifndef CRC_RX_BYTEWISE_EN
            cnt_q     <= 3'd0;
            pend_q    <= 1'b0;
`endif
            ok_q      <= 1'b0;
            ovr_out_q <= 1'b0;
            len_out_q <= 9'd0;
            res_out_q <= CRC_INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            ovr_q   <= ovr_d;
`ifndef CRC_RX_BYTEWISE_EN
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
`endif
            if (latch) begin
                ok_q      <= ok_d;
                ovr_out_q <= ovr_d;
                len_out_q <= len_d;
                res_out_q <= crc_d;
            end
        end
    end

    assign bus.rx_ready   = ready;
    assign bus.frame_done = (state_q == DONE);
    assign bus.crc_ok     = ok_q;
    assign bus.overrun    = ovr_out_q;
    assign bus.frame_len  = len_out_q;
    assign bus.crc_res    = res_out_q;
endmodule

// File: doc/modbus_crc16_rx_check.md
# modbus_crc16_rx_check

Receive-side CRC-16/MODBUS checker for the concentrator's RTU link. It consumes the byte stream from the UART receiver, including the two trailing CRC bytes sent low byte first. It runs the same reflected polynomial (0xA001, init 0xFFFF) as the transmit-side generator. At end of frame it reports a pass/fail verdict, the frame length and the residual CRC to the frame parser.

## Interface
Parameters:
- MAX_LEN, 256: maximum legal frame length in bytes, including CRC.
- MIN_LEN, 4: minimum legal frame length in bytes (address + function + 2 CRC).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received data byte.
- rx_valid  in  1  rx_byte is valid this cycle.
- rx_ready  out  1  block can accept a byte this cycle.
- eof  in  1  one-cycle end-of-frame strobe from the 3.5-character silence timer.
- frame_done  out  1  one-cycle pulse; verdict outputs are valid in this cycle and held until the next pulse.
- crc_ok  out  1  frame passed: residual == 0x0000, MIN_LEN <= length <= MAX_LEN, no overrun.
- overrun  out  1  frame exceeded MAX_LEN bytes.
- frame_len  out  9  number of bytes in the frame, saturating at MAX_LEN.
- crc_res  out  16  residual CRC register value at end of frame.

## Operation
- Running CRC is taken over every byte of the frame, including the CRC bytes; a correct frame leaves residual 0x0000.
- FSM states:
  - IDLE: rx_ready = 1; waits for a byte or eof.
  - SHIFT: eight single-bit steps; each step shifts CRC right by 1 and XORs with 0xA001 if the bit shifted out was 1.
  - DONE: one cycle; drives frame_done and latches the outputs.
- Byte accept: rx_valid && rx_ready at a rising edge.
  - CRC[7:0] ^= rx_byte.
  - frame_len increments if below MAX_LEN; a byte arriving at MAX_LEN sets overrun, and the byte is still consumed but its CRC effect is irrelevant.
  - Transition to SHIFT.
- eof in IDLE with frame_len > 0: go to DONE. eof in IDLE with frame_len == 0: ignored; no pulse.
- eof during SHIFT, or in the same cycle as a byte accept: latched as pending. After the eighth shift, go to DONE instead of IDLE.
- DONE:
  - Latch crc_res, frame_len, overrun and crc_ok into the output registers; pulse frame_done.
  - Reinitialise CRC = 0xFFFF, length = 0, internal overrun = 0, pending = 0.
  - Return to IDLE.
- rx_valid while rx_ready = 0 is not a transfer; the upstream holds the byte.

## Timing
- Reset values: rx_ready = 1; frame_done, crc_ok and overrun = 0; frame_len = 0; crc_res = 0xFFFF; internal CRC = 0xFFFF; state IDLE.
- Byte accepted at edge k: shift steps occur at edges k+1..k+8, and rx_ready = 0 from after edge k until edge k+8.
- Next byte can be accepted at edge k+9, giving a throughput of 9 cycles per byte.
- eof in IDLE at edge e: DONE state, and frame_done = 1, in the cycle after edge e.
- eof pending: frame_done follows the last shift by one cycle, i.e. it is high in the cycle after edge k+8.
- rx_ready = 0 in DONE; the next frame's first byte can be accepted one cycle after frame_done.
- Reset mid-frame: all state returns to reset values immediately; no frame_done pulse; the partial frame is discarded.

## Configuration
- CRC_RX_BYTEWISE_EN defined:
  - The 8 shift steps are unrolled combinationally; the CRC update completes at the accept edge and SHIFT is skipped.
  - rx_ready stays 1 except in DONE, giving one byte per cycle.
  - eof with a same-cycle byte includes that byte and reaches DONE on the next edge.
- CRC_RX_BYTEWISE_EN undefined: bit-serial behaviour as above.
- Verdict values are identical in both builds.

## Test plan
- Frame 01 03 00 00 00 01 84 0A, then eof → frame_done with crc_ok = 1, crc_res = 0x0000, frame_len = 8, overrun = 0.
- Same frame with byte 4 changed from 00 to 01 → crc_ok = 0, crc_res != 0x0000, frame_len = 8.
- Frame of 3 bytes (01 03 00) → crc_ok = 0, frame_len = 3.
- 257 bytes, then eof → overrun = 1, frame_len = 256, crc_ok = 0. A following valid 8-byte frame → crc_ok = 1, overrun = 0.
- eof asserted in the same cycle as the last byte (0A) is accepted → exactly one frame_done, 9 cycles later (bit-serial build), with crc_ok = 1.
- rst_n low during SHIFT of byte 3 → no frame_done; outputs at reset values. A fresh 8-byte valid frame afterwards → crc_ok = 1.
